// File: rtl/fetch_control.sv
// Instruction-fetch front end: PC register, i-cache request, IF/ID register and
// redirect sequencing so an in-flight fetch completes before a redirect lands.
module fetch_control #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        hazard,
  input  logic        mem_busy,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic [15:0] stall_count,
  output logic [15:0] squash_count
);

  typedef enum logic [1:0] {StRun, StRedirPend, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] squash_count_q, squash_count_d;

  logic        advance;
  logic        redir;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        stall_inc;
  logic        squash_inc;

  assign advance  = !hazard && !mem_busy;
  assign redir    = advance && (branch || jump);
  assign target   = branch ? branch_target : jump_target;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    id_instr_d    = id_instr_q;
    id_pc4_d      = id_pc4_q;
    id_valid_d    = id_valid_q;
    stall_inc     = 1'b0;
    squash_inc    = 1'b0;

    unique case (state_q)
      StRun: begin
        if (!advance) begin
          stall_inc = 1'b1;
        end else begin
          // Every accepted cycle that does not deliver a fresh word loads a bubble.
          id_instr_d = 32'h0;
          id_pc4_d   = 32'h0;
          id_valid_d = 1'b0;
          if (halt) begin
            state_d = StHalted;
          end else if (redir) begin
            if (ihit) begin
              pc_d       = target;
              squash_inc = 1'b1;
            end else begin
              pend_target_d = target;
              state_d       = StRedirPend;
            end
          end else if (ihit) begin
            pc_d       = pc_plus4;
            id_instr_d = imemload;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
          end
        end
      end
      StRedirPend: begin
        if (!advance) begin
          stall_inc = 1'b1;
        end else begin
          id_instr_d = 32'h0;
          id_pc4_d   = 32'h0;
          id_valid_d = 1'b0;
          if (halt) begin
            state_d = StHalted;
          end else if (ihit) begin
            // The old-address fetch finished; drop its word and take the redirect.
            pc_d       = pend_target_q;
            squash_inc = 1'b1;
            state_d    = StRun;
          end
        end
      end
      StHalted: begin
      end
      default: begin
        state_d = StRun;
      end
    endcase

    stall_count_d  = (stall_inc && (stall_count_q != 16'hFFFF)) ?
                     stall_count_q + 16'd1 : stall_count_q;
    squash_count_d = (squash_inc && (squash_count_q != 16'hFFFF)) ?
                     squash_count_q + 16'd1 : squash_count_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q        <= StRun;
      pc_q           <= PC_INIT;
      pend_target_q  <= 32'h0;
      id_instr_q     <= 32'h0;
      id_pc4_q       <= 32'h0;
      id_valid_q     <= 1'b0;
      stall_count_q  <= 16'h0;
      squash_count_q <= 16'h0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pend_target_q  <= pend_target_d;
      id_instr_q     <= id_instr_d;
      id_pc4_q       <= id_pc4_d;
      id_valid_q     <= id_valid_d;
      stall_count_q  <= stall_count_d;
      squash_count_q <= squash_count_d;
    end
  end

  assign imemREN      = (state_q != StHalted);
  assign imemaddr     = pc_q;
  assign id_instr     = id_instr_q;
  assign id_pc4       = id_pc4_q;
  assign id_valid     = id_valid_q;
  assign stall_count  = stall_count_q;
  assign squash_count = squash_count_q;

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control: straight-line fetch, stalls, redirects,
// pending redirects, halt, PC wrap and counter saturation.
module tb_fetch_control;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        hazard;
  logic        mem_busy;
  logic        branch;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        halt;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic [15:0] stall_count;
  logic [15:0] squash_count;

  int checks = 0;
  int errors = 0;

  fetch_control dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .ihit          (ihit),
    .imemload      (imemload),
    .imemREN       (imemREN),
    .imemaddr      (imemaddr),
    .hazard        (hazard),
    .mem_busy      (mem_busy),
    .branch        (branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt          (halt),
    .id_instr      (id_instr),
    .id_pc4        (id_pc4),
    .id_valid      (id_valid),
    .stall_count   (stall_count),
    .squash_count  (squash_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ihit          = 1'b0;
    imemload      = 32'h0;
    hazard        = 1'b0;
    mem_busy      = 1'b0;
    branch        = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;
    halt          = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    nRST = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if (imemaddr !== 32'h0) begin
      errors++; $display("FAIL reset_addr got %h exp %h", imemaddr, 32'h0);
    end
    checks++;
    if (imemREN !== 1'b1) begin
      errors++; $display("FAIL reset_ren got %b exp 1", imemREN);
    end
    tick();
    checks++;
    if ({id_instr, id_pc4, id_valid} !== 65'h0) begin
      errors++; $display("FAIL reset_ifid got %h %h %b exp 0 0 0", id_instr, id_pc4, id_valid);
    end
    checks++;
    if ({stall_count, squash_count} !== 32'h0) begin
      errors++; $display("FAIL reset_counts got %h %h exp 0 0", stall_count, squash_count);
    end
    nRST = 1'b1;
  endtask

  task automatic test_straight_line();
    do_reset();
    ihit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imemaddr !== 32'(i * 4)) begin
        errors++; $display("FAIL straight_addr%0d got %h exp %h", i, imemaddr, i * 4);
      end
      imemload = 32'hA000_0000 + 32'(i);
      tick();
      checks++;
      if (id_pc4 !== 32'(i * 4 + 4) || id_valid !== 1'b1 ||
          id_instr !== 32'hA000_0000 + 32'(i)) begin
        errors++;
        $display("FAIL straight_ifid%0d got %h %h %b exp %h %h 1", i, id_instr, id_pc4,
                 id_valid, 32'hA000_0000 + 32'(i), i * 4 + 4);
      end
    end
    ihit = 1'b0;
  endtask

  task automatic test_hazard();
    do_reset();
    ihit = 1'b1;
    imemload = 32'h1111_0000;
    tick();
    imemload = 32'h1111_0004;
    tick();
    hazard = 1'b1;
    imemload = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imemaddr !== 32'h8 || id_pc4 !== 32'h8 || id_instr !== 32'h1111_0004 ||
          id_valid !== 1'b1) begin
        errors++;
        $display("FAIL hazard_hold%0d got %h %h %h %b exp 8 8 11110004 1", i, imemaddr, id_pc4,
                 id_instr, id_valid);
      end
    end
    checks++;
    if (stall_count !== 16'd3) begin
      errors++; $display("FAIL hazard_stall_count got %0d exp 3", stall_count);
    end
    hazard = 1'b0;
    mem_busy = 1'b1;
    tick();
    checks++;
    if (stall_count !== 16'd4 || imemaddr !== 32'h8) begin
      errors++; $display("FAIL membusy_stall got %0d %h exp 4 8", stall_count, imemaddr);
    end
    mem_busy = 1'b0;
    imemload = 32'h1111_0008;
    tick();
    checks++;
    if (imemaddr !== 32'hC || id_pc4 !== 32'hC || id_instr !== 32'h1111_0008) begin
      errors++;
      $display("FAIL hazard_resume got %h %h %h exp c c 11110008", imemaddr, id_pc4, id_instr);
    end
    ihit = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    ihit = 1'b1;
    imemload = 32'h2222_2222;
    repeat (4) tick();
    checks++;
    if (imemaddr !== 32'h10) begin
      errors++; $display("FAIL branch_setup got %h exp 10", imemaddr);
    end
    branch = 1'b1;
    branch_target = 32'h40;
    tick();
    checks++;
    if (imemaddr !== 32'h40 || id_valid !== 1'b0 || id_instr !== 32'h0 ||
        squash_count !== 16'd1) begin
      errors++;
      $display("FAIL branch_taken got %h %b %h %0d exp 40 0 0 1", imemaddr, id_valid, id_instr,
               squash_count);
    end
    jump = 1'b1;
    branch_target = 32'h100;
    jump_target = 32'h200;
    tick();
    checks++;
    if (imemaddr !== 32'h100 || squash_count !== 16'd2) begin
      errors++; $display("FAIL branch_priority got %h %0d exp 100 2", imemaddr, squash_count);
    end
    jump = 1'b0;
    hazard = 1'b1;
    branch_target = 32'h300;
    tick();
    checks++;
    if (imemaddr !== 32'h100 || squash_count !== 16'd2) begin
      errors++; $display("FAIL branch_stalled got %h %0d exp 100 2", imemaddr, squash_count);
    end
    clear_inputs();
  endtask

  task automatic test_jump_pending();
    do_reset();
    ihit = 1'b1;
    repeat (2) tick();
    ihit = 1'b0;
    jump = 1'b1;
    jump_target = 32'h80;
    tick();
    jump = 1'b0;
    checks++;
    if (imemaddr !== 32'h8 || imemREN !== 1'b1 || id_valid !== 1'b0) begin
      errors++; $display("FAIL pend_hold1 got %h %b %b exp 8 1 0", imemaddr, imemREN, id_valid);
    end
    tick();
    checks++;
    if (imemaddr !== 32'h8 || squash_count !== 16'd0) begin
      errors++; $display("FAIL pend_hold2 got %h %0d exp 8 0", imemaddr, squash_count);
    end
    ihit = 1'b1;
    imemload = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (imemaddr !== 32'h80 || id_valid !== 1'b0 || id_instr !== 32'h0 ||
        squash_count !== 16'd1) begin
      errors++;
      $display("FAIL pend_land got %h %b %h %0d exp 80 0 0 1", imemaddr, id_valid, id_instr,
               squash_count);
    end
    imemload = 32'h0000_1234;
    tick();
    checks++;
    if (imemaddr !== 32'h84 || id_instr !== 32'h0000_1234 || id_pc4 !== 32'h84 ||
        id_valid !== 1'b1) begin
      errors++;
      $display("FAIL pend_after got %h %h %h %b exp 84 1234 84 1", imemaddr, id_instr, id_pc4,
               id_valid);
    end
    // Reset while a redirect is pending must forget the target.
    ihit = 1'b0;
    jump = 1'b1;
    jump_target = 32'h500;
    tick();
    do_reset();
    ihit = 1'b1;
    tick();
    checks++;
    if (imemaddr !== 32'h4 || squash_count !== 16'd0) begin
      errors++; $display("FAIL pend_reset got %h %0d exp 4 0", imemaddr, squash_count);
    end
    clear_inputs();
  endtask

  task automatic test_halt();
    do_reset();
    ihit = 1'b1;
    tick();
    halt = 1'b1;
    branch = 1'b1;
    branch_target = 32'h40;
    tick();
    checks++;
    if (imemREN !== 1'b0 || imemaddr !== 32'h4 || id_valid !== 1'b0 ||
        squash_count !== 16'd0) begin
      errors++;
      $display("FAIL halt_enter got %b %h %b %0d exp 0 4 0 0", imemREN, imemaddr, id_valid,
               squash_count);
    end
    halt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      hazard = (i >= 6);
      tick();
      checks++;
      if (imemREN !== 1'b0 || imemaddr !== 32'h4 || id_valid !== 1'b0) begin
        errors++;
        $display("FAIL halt_frozen%0d got %b %h %b exp 0 4 0", i, imemREN, imemaddr, id_valid);
      end
    end
    checks++;
    if (stall_count !== 16'd0) begin
      errors++; $display("FAIL halt_no_stall got %0d exp 0", stall_count);
    end
    nRST = 1'b0;
    #1;
    checks++;
    if (imemaddr !== 32'h0 || imemREN !== 1'b1) begin
      errors++; $display("FAIL halt_reset got %h %b exp 0 1", imemaddr, imemREN);
    end
    nRST = 1'b1;
    clear_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    ihit = 1'b1;
    branch = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch = 1'b0;
    imemload = 32'h5555_AAAA;
    tick();
    checks++;
    if (imemaddr !== 32'h0 || id_pc4 !== 32'h0 || id_valid !== 1'b1 ||
        id_instr !== 32'h5555_AAAA) begin
      errors++;
      $display("FAIL pc_wrap got %h %h %b %h exp 0 0 1 5555aaaa", imemaddr, id_pc4, id_valid,
               id_instr);
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    hazard = 1'b1;
    repeat (65534) tick();
    checks++;
    if (stall_count !== 16'hFFFE) begin
      errors++; $display("FAIL sat_pre got %h exp fffe", stall_count);
    end
    tick();
    checks++;
    if (stall_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_reach got %h exp ffff", stall_count);
    end
    repeat (4465) tick();
    checks++;
    if (stall_count !== 16'hFFFF || imemaddr !== 32'h0) begin
      errors++; $display("FAIL sat_hold got %h %h exp ffff 0", stall_count, imemaddr);
    end
    clear_inputs();
  endtask

  initial begin
    nRST = 1'b1;
    clear_inputs();
    test_reset();
    test_straight_line();
    test_hazard();
    test_branch();
    test_jump_pending();
    test_halt();
    test_wrap();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
